// File: rtl/thermal_frame_reader_pkg.sv
// Shared types and sensor defaults for the thermal-camera frame reader.
// The state encoding is shared so the FSM and any debug tap decode it the same way.
package thermal_frame_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WAIT_CTRL    = 3'd1,
        ST_WRITE        = 3'd2,
        ST_WAIT_RESTART = 3'd3,
        ST_READ         = 3'd4,
        ST_DONE         = 3'd5,
        ST_FAULT        = 3'd6
    } state_e;

    localparam logic [6:0]  DEF_DEVICE_ADDRESS = 7'h33;
    localparam logic [15:0] DEF_START_REG      = 16'h0400;
    localparam int          SENSOR_WORD_COUNT  = 832;
    localparam int          DEF_ADDR_WIDTH     = 10;
    localparam int          DEF_TIMEOUT_CYCLES = 65535;

    // States in which a controller NACK aborts the frame.
    function automatic logic nack_sensitive(input state_e s);
        return (s == ST_WAIT_CTRL) || (s == ST_WRITE) ||
               (s == ST_WAIT_RESTART) || (s == ST_READ);
    endfunction

endpackage

// File: rtl/frame_reader_watchdog.sv
// Loadable down-counter: reloads on clear, counts down while enabled,
// and flags expiry once it has reached zero with counting still enabled.
module frame_reader_watchdog #(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] LOAD_VALUE = '1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expired_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= LOAD_VALUE;
        end else if (clear_i) begin
            cnt_q <= LOAD_VALUE;
        end else if (count_en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign expired_o = count_en_i && (cnt_q == '0);

endmodule

// File: rtl/thermal_frame_reader.sv
// Frame sequencer in front of the I2C controller: writes the start-register
// pointer, restarts, reads WORD_COUNT 16-bit words and streams them to pixel RAM.
module thermal_frame_reader
    import thermal_frame_reader_pkg::*;
#(
    parameter logic [6:0]  DEVICE_ADDRESS = DEF_DEVICE_ADDRESS,
    parameter logic [15:0] START_REG      = DEF_START_REG,
    parameter int          WORD_COUNT     = SENSOR_WORD_COUNT,
    parameter int          ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    input  logic                  i2c_idle_i,
    input  logic                  i2c_ack_i,
    input  logic                  i2c_nack_i,
    input  logic [7:0]            i2c_received_data_i,
    output logic [6:0]            i2c_address_o,
    output logic                  i2c_read_write_o,
    output logic [7:0]            i2c_transmit_data_o,
    output logic                  i2c_enable_transfer_o,
    output logic                  i2c_issue_restart_o,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [15:0]           wr_data_o
);

    localparam int            BW        = ADDR_WIDTH + 1;
    localparam logic [BW-1:0] LAST_BYTE = BW'(2 * WORD_COUNT - 1);
    localparam int            WD_W      = $clog2(TIMEOUT_CYCLES + 1);
    // Load two short so the error pulse lands exactly TIMEOUT_CYCLES after the last ack.
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 2);

    state_e                  state_q;
    logic                    widx_q;
    logic                    seen_low_q;
    logic [BW-1:0]           byte_q;
    logic [7:0]              hi_q;
    logic                    busy_q, done_q, error_q;
    logic                    rw_q, restart_q;
    logic                    wr_en_q;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    logic [15:0]             wr_data_q;

    logic       in_write, in_read, xfer_active;
    logic       last_ack, wd_expired, timeout, fault;
    logic [15:0] word_d;

    assign in_write    = (state_q == ST_WRITE);
    assign in_read     = (state_q == ST_READ);
    assign xfer_active = in_write || in_read;
    assign word_d      = {hi_q, i2c_received_data_i};

    // Dropping enable in the final ack cycle is what tells the controller to stop.
    assign last_ack = i2c_ack_i && ((in_write && widx_q) ||
                                    (in_read && (byte_q == LAST_BYTE)));

    frame_reader_watchdog #(
        .WIDTH      (WD_W),
        .LOAD_VALUE (WD_LOAD)
    ) u_watchdog (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clear_i    (!xfer_active || i2c_ack_i),
        .count_en_i (xfer_active),
        .expired_o  (wd_expired)
    );

    assign timeout = wd_expired && !i2c_ack_i;
    assign fault   = (nack_sensitive(state_q) && i2c_nack_i) || timeout;

    always_comb begin
        i2c_enable_transfer_o = xfer_active && !i2c_nack_i && !last_ack;
        i2c_transmit_data_o   = 8'h00;
        if (in_write) begin
            i2c_transmit_data_o = (widx_q || i2c_ack_i) ? START_REG[7:0] : START_REG[15:8];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            widx_q     <= 1'b0;
            seen_low_q <= 1'b0;
            byte_q     <= '0;
            hi_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            rw_q       <= 1'b0;
            restart_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            wr_en_q <= 1'b0;
            // A simultaneous nack and timeout collapse into one error pulse here.
            if (fault) begin
                state_q   <= ST_FAULT;
                error_q   <= 1'b1;
                rw_q      <= 1'b0;
                restart_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_i) begin
                            state_q <= ST_WAIT_CTRL;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_WAIT_CTRL: begin
                        if (i2c_idle_i) begin
                            state_q   <= ST_WRITE;
                            widx_q    <= 1'b0;
                            rw_q      <= 1'b0;
                            restart_q <= 1'b1;
                        end
                    end
                    ST_WRITE: begin
                        if (i2c_ack_i) begin
                            if (widx_q) begin
                                state_q    <= ST_WAIT_RESTART;
                                seen_low_q <= 1'b0;
                            end else begin
                                widx_q <= 1'b1;
                            end
                        end
                    end
                    ST_WAIT_RESTART: begin
                        // The controller must go busy (restart) and come back idle.
                        if (!i2c_idle_i) begin
                            seen_low_q <= 1'b1;
                        end else if (seen_low_q) begin
                            state_q   <= ST_READ;
                            rw_q      <= 1'b1;
                            restart_q <= 1'b0;
                            byte_q    <= '0;
                        end
                    end
                    ST_READ: begin
                        if (i2c_ack_i) begin
                            if (!byte_q[0]) begin
                                hi_q <= i2c_received_data_i;
                            end else begin
                                wr_en_q   <= 1'b1;
                                wr_addr_q <= byte_q[ADDR_WIDTH:1];
                                wr_data_q <= word_d;
                            end
                            if (byte_q == LAST_BYTE) begin
                                state_q <= ST_DONE;
                                rw_q    <= 1'b0;
                            end else begin
                                byte_q <= byte_q + BW'(1);
                            end
                        end
                    end
                    ST_DONE: begin
                        if (i2c_idle_i) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                    ST_FAULT: begin
                        if (i2c_idle_i) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy_o              = busy_q;
    assign done_o              = done_q;
    assign error_o             = error_q;
    assign i2c_address_o       = DEVICE_ADDRESS;
    assign i2c_read_write_o    = rw_q;
    assign i2c_issue_restart_o = restart_q;
    assign wr_en_o             = wr_en_q;
    assign wr_addr_o           = wr_addr_q;
    assign wr_data_o           = wr_data_q;

endmodule

// File: tb/tb_thermal_frame_reader.sv
// Frame reader bench: behavioural I2C controller model drives the DUT, a
// scoreboard queue holds expected RAM writes, a forked monitor pops and compares.
module tb_thermal_frame_reader;

    localparam logic [6:0]  DEV  = 7'h33;
    localparam logic [15:0] SREG = 16'h0400;
    localparam int          WC   = 4;
    localparam int          AW   = 2;
    localparam int          TMO  = 100;

    localparam int M_NORMAL = 0;
    localparam int M_NACK   = 1;
    localparam int M_STALL  = 2;
    localparam int M_RESET  = 3;
    localparam int M_BUSY   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          i2c_idle = 1'b1, i2c_ack = 1'b0, i2c_nack = 1'b0;
    logic [7:0]    rx = 8'h00;
    logic          busy, done, error, rw, en, restart, wr_en;
    logic [6:0]    addr7;
    logic [7:0]    tx;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;

    thermal_frame_reader #(
        .DEVICE_ADDRESS (DEV),
        .START_REG      (SREG),
        .WORD_COUNT     (WC),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i                 (clk),
        .reset_i               (rst),
        .start_i               (start),
        .busy_o                (busy),
        .done_o                (done),
        .error_o               (error),
        .i2c_idle_i            (i2c_idle),
        .i2c_ack_i             (i2c_ack),
        .i2c_nack_i            (i2c_nack),
        .i2c_received_data_i   (rx),
        .i2c_address_o         (addr7),
        .i2c_read_write_o      (rw),
        .i2c_transmit_data_o   (tx),
        .i2c_enable_transfer_o (en),
        .i2c_issue_restart_o   (restart),
        .wr_en_o               (wr_en),
        .wr_addr_o             (wr_addr),
        .wr_data_o             (wr_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } exp_t;
    exp_t exp_q[$];

    int total = 0, bad = 0;
    int done_cnt = 0, err_cnt = 0, wr_cnt = 0, err_cyc = -1, last_ack = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (t=%0t)", nm, got, want, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (wr_en) begin
                wr_cnt++;
                chk("wr_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("wr_addr", wr_addr, e.addr);
                    chk("wr_data", wr_data, e.data);
                end
            end
            if (done) begin
                done_cnt++;
                chk("busy_at_done", busy, 1'b0);
                chk("pending_at_done", exp_q.size(), 0);
            end
            if (error) begin
                err_cnt++;
                err_cyc = cyc;
            end
        end
    endtask

    task automatic wait_en(input logic want, input int lim, input string nm);
        for (int i = 0; i < lim; i++) begin
            tick();
            #1;
            if (en === want) break;
        end
        chk(nm, en, want);
    endtask

    task automatic run_frame(input int mode, input int arg, input bit fixed);
        logic [7:0]  b [2*WC];
        logic [15:0] sreg;
        exp_t        e;
        int          d0, e0, w0;
        sreg = SREG;
        d0 = done_cnt; e0 = err_cnt; w0 = wr_cnt;
        for (int i = 0; i < 2*WC; i++) b[i] = fixed ? 8'(i + 1) : 8'($urandom);

        tick(); start = 1'b1;
        tick(); start = 1'b0;
        #1 chk("busy_after_start", busy, 1'b1);

        wait_en(1'b1, 20, "en_write_phase");
        chk("rw_write", rw, 1'b0);
        chk("restart_write", restart, 1'b1);
        chk("ptr_byte0", tx, sreg[15:8]);
        i2c_idle = 1'b0;

        if (mode == M_NACK) begin
            repeat (2) tick();
            i2c_nack = 1'b1;
            #1 chk("en_in_nack", en, 1'b0);
            tick(); i2c_nack = 1'b0;
            repeat (3) tick();
            #1 chk("busy_in_fault", busy, 1'b1);
            i2c_idle = 1'b1;
            repeat (3) tick();
            #3 chk("busy_after_fault", busy, 1'b0);
            chk("nack_err_pulses", err_cnt - e0, 1);
            chk("nack_no_done", done_cnt - d0, 0);
            chk("nack_no_wr", wr_cnt - w0, 0);
            return;
        end

        for (int k = 0; k < 2; k++) begin
            repeat ($urandom_range(1, 3)) tick();
            i2c_ack = 1'b1;
            #1;
            if (k == 0) chk("ptr_byte1", tx, sreg[7:0]);
            chk("en_write_ack", en, k == 0);
            tick(); i2c_ack = 1'b0;
        end

        repeat (2) tick();
        #1 chk("restart_held", restart, 1'b1);
        chk("en_low_restart", en, 1'b0);
        i2c_idle = 1'b1;
        wait_en(1'b1, 20, "en_read_phase");
        chk("rw_read", rw, 1'b1);
        chk("restart_read", restart, 1'b0);
        i2c_idle = 1'b0;

        for (int bi = 0; bi < 2*WC; bi++) begin
            repeat ($urandom_range(1, 3)) tick();
            if (mode == M_RESET && bi == arg) begin
                rst = 1'b1; i2c_ack = 1'b1; rx = b[bi];
                #1 chk("reset_outs", {busy, done, error, rw, tx, en, restart, wr_en, wr_addr, wr_data}, 0);
                tick(); i2c_ack = 1'b0;
                tick(); rst = 1'b0; i2c_idle = 1'b1;
                repeat (2) tick();
                #3 chk("busy_after_reset", busy, 1'b0);
                chk("reset_no_error", err_cnt - e0, 0);
                return;
            end
            if (mode == M_STALL && bi == arg) begin
                wait_en(1'b0, TMO + 20, "en_drop_timeout");
                #3 chk("timeout_cycle", err_cyc, last_ack + TMO);
                chk("timeout_err_pulses", err_cnt - e0, 1);
                i2c_idle = 1'b1;
                repeat (3) tick();
                #3 chk("busy_after_timeout", busy, 1'b0);
                chk("timeout_no_done", done_cnt - d0, 0);
                return;
            end
            i2c_ack = 1'b1; rx = b[bi]; last_ack = cyc;
            if (bi % 2 == 1) begin
                e.addr = AW'(bi / 2);
                e.data = {b[bi-1], b[bi]};
                exp_q.push_back(e);
            end
            #1 chk("en_read_ack", en, bi != 2*WC - 1);
            if (mode == M_BUSY && bi == 3) start = 1'b1;
            tick(); i2c_ack = 1'b0; start = 1'b0;
        end

        repeat (2) tick();
        i2c_idle = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            #1;
            if (!busy) break;
        end
        chk("busy_end", busy, 1'b0);
        #3 chk("done_pulses", done_cnt - d0, 1);
        chk("frame_no_error", err_cnt - e0, 0);
        chk("frame_writes", wr_cnt - w0, WC);
        chk("scoreboard_empty", exp_q.size(), 0);
        if (mode == M_BUSY) begin
            repeat (5) tick();
            #1 chk("busy_start_ignored", busy, 1'b0);
            chk("one_done_per_start", done_cnt - d0, 1);
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        repeat (3) tick();
        #1 chk("reset_state", {busy, done, error, rw, tx, en, restart, wr_en, wr_addr, wr_data}, 0);
        chk("i2c_address", addr7, DEV);
        tick(); rst = 1'b0;

        run_frame(M_NORMAL, 0, 1'b1);
        run_frame(M_NORMAL, 0, 1'b0);
        run_frame(M_NACK,   0, 1'b0);
        run_frame(M_STALL,  5, 1'b0);
        run_frame(M_RESET,  4, 1'b0);
        run_frame(M_NORMAL, 0, 1'b0);
        run_frame(M_BUSY,   0, 1'b0);
        run_frame(M_NORMAL, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout reached t=%0t", $time);
        $fatal(1, "bench timed out");
    end

endmodule

// File: doc/thermal_frame_reader.md
# thermal_frame_reader

Sequencer directly upstream of the I2C controller in the thermal-camera path. On a start pulse it writes a 16-bit start-register pointer to the sensor, then issues a restart and reads a burst of 16-bit words. It drives the controller's handshake lines and streams each assembled word into the pixel RAM through a simple write port. It flags controller NACKs and stalled transfers as errors.

## Interface
- DEVICE_ADDRESS, 7'h33, 7-bit sensor I2C address
- START_REG, 16'h0400, register pointer written before the read burst
- WORD_COUNT, 832, words per frame; 1..2^ADDR_WIDTH
- ADDR_WIDTH, 10, pixel RAM address width
- TIMEOUT_CYCLES, 65535, max cycles between controller acks before fault
- clk  in  1  single clock; all logic on posedge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- start  in  1  one-cycle request to read a frame; ignored unless IDLE
- busy  out  1  high from accepted start until DONE/FAULT returns to IDLE
- done  out  1  one-cycle pulse after the last word is written
- error  out  1  one-cycle pulse on NACK or timeout
- i2c_idle, i2c_ack, i2c_nack  in  1 each  controller status
- i2c_received_data  in  8  controller read byte
- i2c_address  out  7  constant DEVICE_ADDRESS
- i2c_read_write  out  1  0 in write phase, 1 in read phase
- i2c_transmit_data  out  8  pointer byte to send
- i2c_enable_transfer  out  1  controller enable
- i2c_issue_restart  out  1  suppress stop after write phase
- wr_en  out  1  pixel RAM write strobe
- wr_addr  out  ADDR_WIDTH  word index 0..WORD_COUNT-1
- wr_data  out  16  assembled word, high byte received first

## Operation
- States:
  - IDLE
  - WAIT_CTRL: wait i2c_idle=1
  - WRITE: pointer bytes, idx 0..1
  - WAIT_RESTART: wait i2c_idle low then high
  - READ: bytes 0..2*WORD_COUNT-1
  - DONE
  - FAULT: wait i2c_idle=1, then IDLE
- i2c_ack is a one-cycle pulse. Every high cycle counts as one byte.
- WRITE: read_write=0, enable high, issue_restart high.
  - transmit_data is combinational: START_REG[7:0] when idx=1 or (idx=0 and ack), else START_REG[15:8].
  - enable_transfer drops combinationally in the cycle ack is high with idx=1. Next state is WAIT_RESTART.
- WAIT_RESTART: enable low, issue_restart held high until i2c_idle is seen high again. Then READ.
- READ: read_write=1, enable high, issue_restart low.
  - On each ack, capture i2c_received_data: even byte into hi register, odd byte completes the word.
  - enable_transfer drops combinationally in the cycle ack is high on byte 2*WORD_COUNT-1. This makes the controller NACK and stop.
- DONE: wait i2c_idle high, pulse done, go to IDLE.
- i2c_nack high in any active state: enable low combinationally, error pulse, go to FAULT.
- Watchdog: counts cycles in WRITE/READ and resets on every ack. Reaching TIMEOUT_CYCLES pulses error and goes to FAULT. If a nack and the timeout occur in the same cycle, only one error pulse is issued.
- start during busy: ignored. Reset mid-frame: all outputs return to reset values immediately. Partially written RAM contents are left as is.

## Timing
- Reset values: busy=0, done=0, error=0, read_write=0, transmit_data=0, enable_transfer=0, issue_restart=0, wr_en=0, wr_addr=0, wr_data=0. i2c_address is constant.
- start accepted at edge N: busy=1 from N+1.
- wr_en is a one-cycle registered pulse in the cycle after the ack of each odd byte. wr_addr and wr_data are valid with it.
- wr_addr increments after each write. It never wraps inside a frame.
- done rises at least one cycle after the final wr_en. busy falls in the same cycle done pulses.
- Combinational paths: only enable_transfer and transmit_data depend on the current i2c_ack or i2c_nack. Both controller sampling points fall in the ack cycle.

## Structure
- Shared package: state encoding constants, default DEVICE_ADDRESS and START_REG, WORD_COUNT for the sensor.
- One sub-module is natural: frame_reader_watchdog, a loadable down-counter with clear and expiry flag.

## Test plan
- Behavioural controller model, WORD_COUNT=4, START_REG=16'h0400, bytes 01..08:
  - pointer bytes sent are 04 then 00;
  - wr_data is 0102, 0304, 0506, 0708 at addresses 0..3;
  - one done pulse.
- Check that enable_transfer is low in the ack cycle of byte 8 and of pointer byte idx=1, and high in all earlier ack cycles.
- Model NACKs the address: one error pulse, no wr_en, busy clears after i2c_idle=1.
- Model stops acking mid-read with TIMEOUT_CYCLES=100: error exactly 100 cycles after the last ack.
- Assert reset during READ byte 5: every output is at its reset value in the same cycle. A new start after release completes a full frame.
- Pulse start while busy: ignored, exactly one done per accepted start.
